output_sample: RTL and testbench



---
 rtl/output_sample_pkg.sv | 17 +
 rtl/sample_ticker.sv | 28 ++
 rtl/output_sample.sv | 58 +++++
 tb/tb_output_sample.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/output_sample_pkg.sv
// Shared constants and helpers for the windowed input sampler.
// No logic; no latency; no backpressure.
// Holds the period-register width, parameter limits and sum-width rule.
package output_sample_pkg;

    localparam int PERIOD_W  = 16;
    localparam int WIDTH_MIN = 1;
    localparam int DEPTH_MIN = 1;
    localparam int DEPTH_MAX = 8;
    localparam int SUM_W_MAX = 16;

    // Window of 2^depth samples of w bits never needs more than w+depth bits.
    function automatic int sum_width(input int w, input int d);
        return w + d;
    endfunction

endpackage

// File: rtl/sample_ticker.sv
// Sample-period pacer: strobes once every period+1 cycles.
// Strobe is combinational from the counter, so the counter acts on the same edge.
// No backpressure; a lowered period wraps at the next compare.
module sample_ticker
    import output_sample_pkg::*;
(
    input  logic                CLK,
    input  logic                RST,
    input  logic [PERIOD_W-1:0] period,
    output logic                strobe
);

    logic [PERIOD_W-1:0] cnt;

    // >= rather than == so shrinking the period mid-count still wraps.
    assign strobe = (cnt >= period);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (strobe) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PERIOD_W'(1);
        end
    end

endmodule

// File: rtl/output_sample.sv
// Windowed sampler: circular history of 2^DEPTH samples, running sum, readback.
// Sum updates on the strobe edge; readback is registered (1 cycle).
// No handshake; input_1 must be stable at every strobe edge.
module output_sample
    import output_sample_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [WIDTH-1:0]    input_1,
    input  logic [DEPTH-1:0]    input_2,
    input  logic [PERIOD_W-1:0] input_3,
    output logic [15:0]         out_1,
    output logic [WIDTH-1:0]    out_2
);

    localparam int SUM_W   = sum_width(WIDTH, DEPTH);
    localparam int ENTRIES = 1 << DEPTH;

    logic                strobe;
    logic [WIDTH-1:0]    hist [ENTRIES];
    logic [DEPTH-1:0]    wptr;
    logic [SUM_W-1:0]    sum;
    logic [DEPTH-1:0]    rd_idx;

    sample_ticker u_ticker (
        .CLK    (CLK),
        .RST    (RST),
        .period (input_3),
        .strobe (strobe)
    );

    // Offset 0 is the entry just behind the write pointer.
    assign rd_idx = wptr - DEPTH'(1) - input_2;
    assign out_1  = 16'(sum);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                hist[i] <= '0;
            end
            wptr  <= '0;
            sum   <= '0;
            out_2 <= '0;
        end else begin
            out_2 <= hist[rd_idx];
            if (strobe) begin
                // Evicted entry is zero until the window first fills.
                hist[wptr] <= input_1;
                sum        <= sum + SUM_W'(input_1) - SUM_W'(hist[wptr]);
                wptr       <= wptr + DEPTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_output_sample.sv
// Directed bench for output_sample with WIDTH=8, DEPTH=4.
module tb_output_sample;

    logic        CLK;
    logic        RST;
    logic [7:0]  input_1;
    logic [3:0]  input_2;
    logic [15:0] input_3;
    logic [15:0] out_1;
    logic [7:0]  out_2;

    int n_cmp;
    int n_fail;

    output_sample #(.WIDTH(8), .DEPTH(4)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .input_1 (input_1),
        .input_2 (input_2),
        .input_3 (input_3),
        .out_1   (out_1),
        .out_2   (out_2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        #2;
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST     = 1'b1;
        input_1 = 8'h33;
        input_2 = 4'd0;
        input_3 = 16'd0;
        #1;
        n_cmp++;
        if (out_1 !== 16'd0) begin n_fail++; $display("FAIL reset_sum0 got %0d want 0", out_1); end
        n_cmp++;
        if (out_2 !== 8'd0) begin n_fail++; $display("FAIL reset_rd0 got %0d want 0", out_2); end
        step();
        step();
        n_cmp++;
        if (out_1 !== 16'd0) begin n_fail++; $display("FAIL reset_held_sum got %0d want 0", out_1); end
        RST = 1'b0;
        step();
        step();
        n_cmp++;
        if (out_1 !== 16'h66) begin n_fail++; $display("FAIL reset_presum got %0h want 66", out_1); end
        n_cmp++;
        if (out_2 !== 8'h33) begin n_fail++; $display("FAIL reset_prerd got %0h want 33", out_2); end
        // Asynchronous assertion mid-cycle, no edge in between.
        RST = 1'b1;
        #1;
        n_cmp++;
        if (out_1 !== 16'd0) begin n_fail++; $display("FAIL reset_async_sum got %0d want 0", out_1); end
        n_cmp++;
        if (out_2 !== 8'd0) begin n_fail++; $display("FAIL reset_async_rd got %0d want 0", out_2); end
        RST = 1'b0;
    endtask

    task automatic test_ramp();
        int exp_sum [5] = '{1, 3, 6, 10, 15};
        do_reset();
        input_2 = 4'd0;
        input_3 = 16'd0;
        for (int i = 0; i < 5; i++) begin
            input_1 = 8'(i + 1);
            step();
            n_cmp++;
            if (out_1 !== 16'(exp_sum[i])) begin
                n_fail++; $display("FAIL ramp_sum i=%0d got %0d want %0d", i, out_1, exp_sum[i]);
            end
            n_cmp++;
            if (out_2 !== 8'(i)) begin
                n_fail++; $display("FAIL ramp_rd i=%0d got %0d want %0d", i, out_2, i);
            end
        end
        input_1 = 8'd0;
        step();
        n_cmp++;
        if (out_2 !== 8'd5) begin n_fail++; $display("FAIL ramp_rd_last got %0d want 5", out_2); end
        n_cmp++;
        if (out_1 !== 16'd15) begin n_fail++; $display("FAIL ramp_sum_hold got %0d want 15", out_1); end
    endtask

    task automatic test_wrap();
        int e;
        do_reset();
        input_2 = 4'd0;
        input_3 = 16'd0;
        input_1 = 8'hFF;
        for (int i = 1; i <= 20; i++) begin
            step();
            e = (i < 16 ? i : 16) * 255;
            n_cmp++;
            if (out_1 !== 16'(e)) begin
                n_fail++; $display("FAIL wrap_fill i=%0d got %0d want %0d", i, out_1, e);
            end
        end
        input_1 = 8'h00;
        for (int i = 1; i <= 16; i++) begin
            step();
            e = (16 - i) * 255;
            n_cmp++;
            if (out_1 !== 16'(e)) begin
                n_fail++; $display("FAIL wrap_drain i=%0d got %0d want %0d", i, out_1, e);
            end
        end
    endtask

    task automatic test_period();
        int e;
        do_reset();
        input_2 = 4'd0;
        input_3 = 16'd4;
        input_1 = 8'h10;
        for (int j = 1; j <= 15; j++) begin
            step();
            e = 16 * (j / 5);
            n_cmp++;
            if (out_1 !== 16'(e)) begin
                n_fail++; $display("FAIL period j=%0d got %0h want %0h", j, out_1, e);
            end
        end
    endtask

    task automatic test_readback();
        do_reset();
        input_2 = 4'd0;
        input_3 = 16'd0;
        for (int i = 0; i < 8; i++) begin
            input_1 = 8'hA0 + 8'(i);
            step();
        end
        // Park the ticker so the history stays put.
        input_3 = 16'hFFFF;
        n_cmp++;
        if (out_1 !== 16'd1308) begin n_fail++; $display("FAIL rb_sum got %0d want 1308", out_1); end
        input_2 = 4'd3;
        step();
        n_cmp++;
        if (out_2 !== 8'hA4) begin n_fail++; $display("FAIL rb_off3 got %0h want a4", out_2); end
        input_2 = 4'd10;
        step();
        n_cmp++;
        if (out_2 !== 8'h00) begin n_fail++; $display("FAIL rb_off10 got %0h want 0", out_2); end
        input_2 = 4'd0;
        step();
        n_cmp++;
        if (out_2 !== 8'hA7) begin n_fail++; $display("FAIL rb_off0 got %0h want a7", out_2); end
        input_2 = 4'd7;
        step();
        n_cmp++;
        if (out_2 !== 8'hA0) begin n_fail++; $display("FAIL rb_off7 got %0h want a0", out_2); end
        // Counter is at 4; a period of 3 is already exceeded, so this edge strobes.
        input_1 = 8'h01;
        input_3 = 16'd3;
        step();
        n_cmp++;
        if (out_1 !== 16'd1309) begin n_fail++; $display("FAIL rb_lower_period got %0d want 1309", out_1); end
    endtask

    task automatic test_midreset();
        do_reset();
        input_2 = 4'd0;
        input_3 = 16'd0;
        for (int k = 1; k <= 7; k++) begin
            input_1 = 8'(17 * k);
            step();
        end
        n_cmp++;
        if (out_1 !== 16'd476) begin n_fail++; $display("FAIL mid_presum got %0d want 476", out_1); end
        RST = 1'b1;
        #1;
        n_cmp++;
        if (out_1 !== 16'd0) begin n_fail++; $display("FAIL mid_rst_sum got %0d want 0", out_1); end
        n_cmp++;
        if (out_2 !== 8'd0) begin n_fail++; $display("FAIL mid_rst_rd got %0d want 0", out_2); end
        RST = 1'b0;
        input_1 = 8'h05;
        step();
        n_cmp++;
        if (out_1 !== 16'd5) begin n_fail++; $display("FAIL mid_first got %0d want 5", out_1); end
        input_1 = 8'h00;
        step();
        input_3 = 16'hFFFF;
        n_cmp++;
        if (out_2 !== 8'h05) begin n_fail++; $display("FAIL mid_rd got %0h want 5", out_2); end
        n_cmp++;
        if (out_1 !== 16'd5) begin n_fail++; $display("FAIL mid_sum2 got %0d want 5", out_1); end
        // Offset 14 lands on slot 3, which held 0x44 before the reset.
        input_2 = 4'd14;
        step();
        n_cmp++;
        if (out_2 !== 8'h00) begin n_fail++; $display("FAIL mid_stale got %0h want 0", out_2); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_ramp();
        test_wrap();
        test_period();
        test_readback();
        test_midreset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
